// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code event decoder.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_SKIP    = 3'd4
   } ps2_state_e;

   localparam logic [7:0] PFX_E0 = 8'hE0;
   localparam logic [7:0] PFX_F0 = 8'hF0;
   localparam logic [7:0] PFX_E1 = 8'hE1;

   localparam logic [7:0] KEY_LSHIFT = 8'h12;
   localparam logic [7:0] KEY_RSHIFT = 8'h59;
   localparam logic [7:0] KEY_CTRL   = 8'h14;
   localparam logic [7:0] KEY_ALT    = 8'h11;
   localparam logic [7:0] KEY_CAPS   = 8'h58;

   localparam int MOD_CAPS  = 0;
   localparam int MOD_SHIFT = 1;
   localparam int MOD_CTRL  = 2;
   localparam int MOD_ALT   = 3;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic       rep;
      logic [3:0] mods;
      logic [7:0] code;
      logic [7:0] ascii;
   } key_event_t;

   // US-layout shifted digit row
   function automatic logic [7:0] shift_digit(input logic [7:0] d);
      case (d)
         8'h30:   return 8'h29;
         8'h31:   return 8'h21;
         8'h32:   return 8'h40;
         8'h33:   return 8'h23;
         8'h34:   return 8'h24;
         8'h35:   return 8'h25;
         8'h36:   return 8'h5E;
         8'h37:   return 8'h26;
         8'h38:   return 8'h2A;
         8'h39:   return 8'h28;
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/ps2_ascii_map.sv
// Scan-code set 2 to base (unshifted, lower-case) ASCII; 0 for keys without a character.
module ps2_ascii_map
   import ps2_pkg::*;
(
   input  logic [7:0] code_i,
   output logic [7:0] ascii_o
);

   always_comb begin
      ascii_o = 8'h00;
      case (code_i)
         8'h1C: ascii_o = 8'h61;  8'h32: ascii_o = 8'h62;  8'h21: ascii_o = 8'h63;
         8'h23: ascii_o = 8'h64;  8'h24: ascii_o = 8'h65;  8'h2B: ascii_o = 8'h66;
         8'h34: ascii_o = 8'h67;  8'h33: ascii_o = 8'h68;  8'h43: ascii_o = 8'h69;
         8'h3B: ascii_o = 8'h6A;  8'h42: ascii_o = 8'h6B;  8'h4B: ascii_o = 8'h6C;
         8'h3A: ascii_o = 8'h6D;  8'h31: ascii_o = 8'h6E;  8'h44: ascii_o = 8'h6F;
         8'h4D: ascii_o = 8'h70;  8'h15: ascii_o = 8'h71;  8'h2D: ascii_o = 8'h72;
         8'h1B: ascii_o = 8'h73;  8'h2C: ascii_o = 8'h74;  8'h3C: ascii_o = 8'h75;
         8'h2A: ascii_o = 8'h76;  8'h1D: ascii_o = 8'h77;  8'h22: ascii_o = 8'h78;
         8'h35: ascii_o = 8'h79;  8'h1A: ascii_o = 8'h7A;
         8'h45: ascii_o = 8'h30;  8'h16: ascii_o = 8'h31;  8'h1E: ascii_o = 8'h32;
         8'h26: ascii_o = 8'h33;  8'h25: ascii_o = 8'h34;  8'h2E: ascii_o = 8'h35;
         8'h36: ascii_o = 8'h36;  8'h3D: ascii_o = 8'h37;  8'h3E: ascii_o = 8'h38;
         8'h46: ascii_o = 8'h39;
         8'h29: ascii_o = 8'h20;  8'h5A: ascii_o = 8'h0D;  8'h66: ascii_o = 8'h08;
         8'h0D: ascii_o = 8'h09;  8'h76: ascii_o = 8'h1B;  8'h4E: ascii_o = 8'h2D;
         8'h55: ascii_o = 8'h3D;  8'h54: ascii_o = 8'h5B;  8'h5B: ascii_o = 8'h5D;
         8'h4C: ascii_o = 8'h3B;  8'h52: ascii_o = 8'h27;  8'h41: ascii_o = 8'h2C;
         8'h49: ascii_o = 8'h2E;  8'h4A: ascii_o = 8'h2F;  8'h0E: ascii_o = 8'h60;
         8'h5D: ascii_o = 8'h5C;
         default: ascii_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code stream -> key events (prefix FSM, modifiers, ASCII) queued in a FWFT FIFO.
// KEY_REPEAT_FILTER_EN: when defined, typematic repeats are silently dropped.
module ps2_key_event_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8,
   parameter bit EMIT_BREAK = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_code,
   output logic             out_ext,
   output logic             out_break,
   output logic             out_repeat,
   output logic [7:0]       out_ascii,
   output logic [3:0]       out_mods,
   output logic             caps_lock,
   output logic [CNT_W-1:0] press_count,
   output logic             overflow
);

`ifdef KEY_REPEAT_FILTER_EN
   localparam bit FILTER_EN = 1'b1;
`else
   localparam bit FILTER_EN = 1'b0;
`endif
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ps2_state_e       state_q, state_d;
   logic [2:0]       skip_q, skip_d;
   logic             lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q, caps_q;
   logic             held_vld_q;
   logic [8:0]       held_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   key_event_t       mem_q [FIFO_DEPTH];
   logic [AW:0]      wr_q, rd_q;

   logic       done, ev_ext, ev_brk, is_make, is_rep, shift, ctrl, alt;
   logic       update, push, pop, full, empty, push_ok;
   logic [8:0] key;
   logic [7:0] base, ev_ascii;
   key_event_t ev, head;

   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      done    = 1'b0;
      ev_ext  = 1'b0;
      ev_brk  = 1'b0;
      if (in_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (in_data == PFX_E0)      state_d = ST_EXT;
               else if (in_data == PFX_F0) state_d = ST_BRK;
               else if (in_data == PFX_E1) begin
                  state_d = ST_SKIP;
                  skip_d  = 3'd7;
               end else done = 1'b1;
            end
            ST_EXT: begin
               if (in_data == PFX_F0) state_d = ST_EXT_BRK;
               else begin
                  done    = 1'b1;
                  ev_ext  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_BRK: begin
               done    = 1'b1;
               ev_brk  = 1'b1;
               state_d = ST_IDLE;
            end
            ST_EXT_BRK: begin
               done    = 1'b1;
               ev_ext  = 1'b1;
               ev_brk  = 1'b1;
               state_d = ST_IDLE;
            end
            ST_SKIP: begin
               skip_d = skip_q - 3'd1;
               if (skip_q == 3'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   ps2_ascii_map u_map (.code_i(in_data), .ascii_o(base));

   assign key     = {ev_ext, in_data};
   assign is_make = done && !ev_brk;
   assign is_rep  = is_make && held_vld_q && (held_q == key);
   assign shift   = lshift_q | rshift_q;
   assign ctrl    = lctrl_q | rctrl_q;
   assign alt     = lalt_q | ralt_q;

   // Letters: ctrl folds to control codes, otherwise case follows caps XOR shift
   always_comb begin
      ev_ascii = 8'h00;
      if (is_make && !ev_ext) begin
         if (base >= 8'h61 && base <= 8'h7A) begin
            if (ctrl)                ev_ascii = base & 8'h1F;
            else if (caps_q ^ shift) ev_ascii = base - 8'h20;
            else                     ev_ascii = base;
         end else if (shift && base >= 8'h30 && base <= 8'h39) begin
            ev_ascii = shift_digit(base);
         end else begin
            ev_ascii = base;
         end
      end
   end

   always_comb begin
      ev                 = '0;
      ev.ext             = ev_ext;
      ev.brk             = ev_brk;
      ev.rep             = is_rep;
      ev.mods[MOD_ALT]   = alt;
      ev.mods[MOD_CTRL]  = ctrl;
      ev.mods[MOD_SHIFT] = shift;
      ev.mods[MOD_CAPS]  = caps_q;
      ev.code            = in_data;
      ev.ascii           = ev_ascii;
   end

   assign update  = done && !(FILTER_EN && is_rep);
   assign push    = update && (!ev_brk || EMIT_BREAK);
   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop     = !empty && out_ready;
   assign push_ok = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         skip_q     <= 3'd0;
         lshift_q   <= 1'b0;
         rshift_q   <= 1'b0;
         lctrl_q    <= 1'b0;
         rctrl_q    <= 1'b0;
         lalt_q     <= 1'b0;
         ralt_q     <= 1'b0;
         caps_q     <= 1'b0;
         held_vld_q <= 1'b0;
         held_q     <= 9'd0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         wr_q       <= '0;
         rd_q       <= '0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         if (update) begin
            if (key == {1'b0, KEY_LSHIFT}) lshift_q <= !ev_brk;
            if (key == {1'b0, KEY_RSHIFT}) rshift_q <= !ev_brk;
            if (key == {1'b0, KEY_CTRL})   lctrl_q  <= !ev_brk;
            if (key == {1'b1, KEY_CTRL})   rctrl_q  <= !ev_brk;
            if (key == {1'b0, KEY_ALT})    lalt_q   <= !ev_brk;
            if (key == {1'b1, KEY_ALT})    ralt_q   <= !ev_brk;
            if (is_make) begin
               held_q     <= key;
               held_vld_q <= 1'b1;
            end else if (held_vld_q && held_q == key) begin
               held_vld_q <= 1'b0;
            end
         end
         if (is_make && !is_rep) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (key == {1'b0, KEY_CAPS}) caps_q <= !caps_q;
         end
         if (push && !push_ok) ovf_q <= 1'b1;
         if (push_ok) wr_q <= wr_q + PTR_ONE;
         if (pop)     rd_q <= rd_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q[AW-1:0]] <= ev;
   end

   assign head        = empty ? '0 : mem_q[rd_q[AW-1:0]];
   assign out_valid   = !empty;
   assign out_code    = head.code;
   assign out_ext     = head.ext;
   assign out_break   = head.brk;
   assign out_repeat  = head.rep;
   assign out_ascii   = head.ascii;
   assign out_mods    = head.mods;
   assign caps_lock   = caps_q;
   assign press_count = cnt_q;
   assign overflow    = ovf_q;

endmodule
